// File: rtl/color_history_updater.sv
`default_nettype none
// ============================================================================
//  Module   : color_history_updater
//  Purpose  : Read-modify-write front end for the color_history memory.
//             Each accepted camera pixel reads its 4-bit history nibble
//             {colour[1:0], conf[1:0]} and applies a saturating-confidence
//             update. The result is written back and also emitted as a
//             temporally filtered colour for the blob/centroid logic.
//             Read-after-write hazards inside the memory pipeline are covered
//             by a small forwarding table of recent write-backs.
//  Ports    : clk, reset                - clock, asynchronous active-high reset
//             pix_valid/pix_ready       - input pixel handshake
//             pix_x/pix_y/pix_class     - pixel coordinates and classification
//             hist_read_addr            - read address to color_history
//             hist_read_data/_valid     - read data / ready indication from it
//             hist_just_read_addr       - address the returned data belongs to
//             hist_write_addr/_data/_en - write-back port to color_history
//             out_valid/out_x/out_y     - filtered pixel strobe and coordinates
//             out_color/out_stable      - updated colour, confidence >= THRESH
//             addr_mismatch             - sticky read-address tracking error
//  Revision : 1.0 - initial release
// ============================================================================
module color_history_updater #(
    parameter int unsigned H_RES     = 640,
    parameter int unsigned RD_LAT    = 3,
    parameter int unsigned THRESH    = 2,
    // Must be at least RD_LAT+2 so every write still in flight is visible.
    parameter int unsigned FWD_DEPTH = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [1:0]  pix_class,
    output logic [18:0] hist_read_addr,
    input  logic [3:0]  hist_read_data,
    input  logic        hist_data_valid,
    input  logic [18:0] hist_just_read_addr,
    output logic [18:0] hist_write_addr,
    output logic [3:0]  hist_write_data,
    output logic        hist_write_en,
    output logic        out_valid,
    output logic [9:0]  out_x,
    output logic [8:0]  out_y,
    output logic [1:0]  out_color,
    output logic        out_stable,
    output logic        addr_mismatch
);

    // ------------------------------------------------------------------------
    // State machine: PRIME waits for color_history to finish its clear,
    // RUN is only left through reset.
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_PRIME = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_pix_ready;
    logic       w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_PRIME: if (hist_data_valid) w_state_nxt = c_ST_RUN;
            c_ST_RUN:   w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_PRIME;
        endcase
    end

    always_comb begin
        w_pix_ready = 1'b0;
        case (r_state)
            c_ST_PRIME: w_pix_ready = 1'b0;
            c_ST_RUN:   w_pix_ready = 1'b1;
            default:    w_pix_ready = 1'b0;
        endcase
    end

    assign pix_ready = w_pix_ready;
    assign w_accept  = pix_valid & w_pix_ready;

    // ------------------------------------------------------------------------
    // Linear address y*H_RES + x. For the 640-wide sensor this is two shifts
    // and two adds (640 = 512 + 128); other widths fall back to a multiply.
    // ------------------------------------------------------------------------
    logic [18:0] w_pix_addr;

    generate
        if (H_RES == 640) begin : g_addr_shift
            assign w_pix_addr = ({10'd0, pix_y} << 9) + ({10'd0, pix_y} << 7) + {9'd0, pix_x};
        end else begin : g_addr_mul
            assign w_pix_addr = ({10'd0, pix_y} * 19'(H_RES)) + {9'd0, pix_x};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Tag delay line. Stage 0 is the read-address stage: its address register
    // drives hist_read_addr directly and only reloads on an accepted pixel, so
    // the port holds 0 through PRIME and holds its last value over bubbles.
    // Stage RD_LAT lines up with the returning read data.
    // ------------------------------------------------------------------------
    logic        r_tag_valid [0:RD_LAT];
    logic [18:0] r_tag_addr  [0:RD_LAT];
    logic [9:0]  r_tag_x     [0:RD_LAT];
    logic [8:0]  r_tag_y     [0:RD_LAT];
    logic [1:0]  r_tag_class [0:RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                r_tag_valid[i] <= 1'b0;
                r_tag_addr[i]  <= 19'd0;
                r_tag_x[i]     <= 10'd0;
                r_tag_y[i]     <= 9'd0;
                r_tag_class[i] <= 2'd0;
            end
        end else begin
            r_tag_valid[0] <= w_accept;
            if (w_accept) begin
                r_tag_addr[0]  <= w_pix_addr;
                r_tag_x[0]     <= pix_x;
                r_tag_y[0]     <= pix_y;
                r_tag_class[0] <= pix_class;
            end
            if (r_state == c_ST_RUN) begin
                for (int i = int'(RD_LAT); i >= 1; i--) begin
                    r_tag_valid[i] <= r_tag_valid[i-1];
                    r_tag_addr[i]  <= r_tag_addr[i-1];
                    r_tag_x[i]     <= r_tag_x[i-1];
                    r_tag_y[i]     <= r_tag_y[i-1];
                    r_tag_class[i] <= r_tag_class[i-1];
                end
            end
        end
    end

    assign hist_read_addr = r_tag_addr[0];

    logic        w_em_valid;
    logic [18:0] w_em_addr;
    logic [1:0]  w_em_class;

    assign w_em_valid = r_tag_valid[RD_LAT];
    assign w_em_addr  = r_tag_addr[RD_LAT];
    assign w_em_class = r_tag_class[RD_LAT];

    // ------------------------------------------------------------------------
    // Forwarding table, index 0 newest. Memory data may predate writes that
    // are still in flight, so the newest matching table entry wins.
    // ------------------------------------------------------------------------
    logic        r_fwd_valid [0:FWD_DEPTH-1];
    logic [18:0] r_fwd_addr  [0:FWD_DEPTH-1];
    logic [3:0]  r_fwd_data  [0:FWD_DEPTH-1];
    logic [3:0]  w_old;

    always_comb begin
        w_old = hist_read_data;
        // Walk oldest to newest so the newest match is the one left standing.
        for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
            if (r_fwd_valid[i] && (r_fwd_addr[i] == w_em_addr)) begin
                w_old = r_fwd_data[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturating confidence update. A differing class first erodes the
    // confidence; only at zero confidence is the stored colour replaced.
    // ------------------------------------------------------------------------
    logic [1:0] w_old_color;
    logic [1:0] w_old_conf;
    logic [1:0] w_new_color;
    logic [1:0] w_new_conf;
    logic       w_new_stable;

    assign w_old_color = w_old[3:2];
    assign w_old_conf  = w_old[1:0];

    always_comb begin
        w_new_color = w_old_color;
        w_new_conf  = w_old_conf;
        if (w_em_class == w_old_color) begin
            if (w_old_conf != 2'd3) begin
                w_new_conf = w_old_conf + 2'd1;
            end
        end else if (w_old_conf != 2'd0) begin
            w_new_conf = w_old_conf - 2'd1;
        end else begin
            w_new_color = w_em_class;
            w_new_conf  = 2'd0;
        end
    end

    assign w_new_stable = ({30'd0, w_new_conf} >= THRESH);

    // ------------------------------------------------------------------------
    // Write-back and filtered output. Data fields hold when no tag emerges.
    // ------------------------------------------------------------------------
    logic        r_write_en;
    logic [18:0] r_write_addr;
    logic [3:0]  r_write_data;
    logic        r_out_valid;
    logic [9:0]  r_out_x;
    logic [8:0]  r_out_y;
    logic [1:0]  r_out_color;
    logic        r_out_stable;
    logic        r_mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_en   <= 1'b0;
            r_write_addr <= 19'd0;
            r_write_data <= 4'd0;
            r_out_valid  <= 1'b0;
            r_out_x      <= 10'd0;
            r_out_y      <= 9'd0;
            r_out_color  <= 2'd0;
            r_out_stable <= 1'b0;
        end else if (w_em_valid) begin
            r_write_en   <= 1'b1;
            r_write_addr <= w_em_addr;
            r_write_data <= {w_new_color, w_new_conf};
            r_out_valid  <= 1'b1;
            r_out_x      <= r_tag_x[RD_LAT];
            r_out_y      <= r_tag_y[RD_LAT];
            r_out_color  <= w_new_color;
            r_out_stable <= w_new_stable;
        end else begin
            r_write_en   <= 1'b0;
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FWD_DEPTH); i++) begin
                r_fwd_valid[i] <= 1'b0;
                r_fwd_addr[i]  <= 19'd0;
                r_fwd_data[i]  <= 4'd0;
            end
        end else if (w_em_valid) begin
            r_fwd_valid[0] <= 1'b1;
            r_fwd_addr[0]  <= w_em_addr;
            r_fwd_data[0]  <= {w_new_color, w_new_conf};
            for (int i = 1; i < int'(FWD_DEPTH); i++) begin
                r_fwd_valid[i] <= r_fwd_valid[i-1];
                r_fwd_addr[i]  <= r_fwd_addr[i-1];
                r_fwd_data[i]  <= r_fwd_data[i-1];
            end
        end
    end

    // The memory reports which address its data belongs to; a disagreement
    // means the read pipeline has slipped. Flag it and keep streaming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (w_em_valid && (hist_just_read_addr != w_em_addr)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign hist_write_en   = r_write_en;
    assign hist_write_addr = r_write_addr;
    assign hist_write_data = r_write_data;
    assign out_valid       = r_out_valid;
    assign out_x           = r_out_x;
    assign out_y           = r_out_y;
    assign out_color       = r_out_color;
    assign out_stable      = r_out_stable;
    assign addr_mismatch   = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_color_history_updater.sv
`default_nettype none
// ============================================================================
//  Module   : tb_color_history_updater
//  Purpose  : Self-checking bench for color_history_updater. A latency model
//             of color_history serves reads and absorbs writes; a sequential
//             reference (one history nibble per address, updated in pixel
//             order) predicts every write-back and filtered output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_color_history_updater;

    localparam int c_NPIX = 307200;
    localparam int c_QLEN = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [1:0]  pix_class;
    logic [18:0] hist_read_addr;
    logic [3:0]  hist_read_data;
    logic        hist_data_valid;
    logic [18:0] hist_just_read_addr;
    logic [18:0] hist_write_addr;
    logic [3:0]  hist_write_data;
    logic        hist_write_en;
    logic        out_valid;
    logic [9:0]  out_x;
    logic [8:0]  out_y;
    logic [1:0]  out_color;
    logic        out_stable;
    logic        addr_mismatch;

    logic        corrupt;

    int n_tests = 0;
    int n_fail  = 0;

    color_history_updater dut (
        .clk                 (clk),
        .reset               (reset),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .pix_x               (pix_x),
        .pix_y               (pix_y),
        .pix_class           (pix_class),
        .hist_read_addr      (hist_read_addr),
        .hist_read_data      (hist_read_data),
        .hist_data_valid     (hist_data_valid),
        .hist_just_read_addr (hist_just_read_addr),
        .hist_write_addr     (hist_write_addr),
        .hist_write_data     (hist_write_data),
        .hist_write_en       (hist_write_en),
        .out_valid           (out_valid),
        .out_x               (out_x),
        .out_y               (out_y),
        .out_color           (out_color),
        .out_stable          (out_stable),
        .addr_mismatch       (addr_mismatch)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // color_history model: 3-cycle read pipeline, write on clock edge,
    // cleared whenever reset is high.
    // ------------------------------------------------------------------------
    logic [3:0]  mem  [0:c_NPIX-1];
    logic [18:0] rd_a [0:2];
    logic [3:0]  rd_d [0:2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NPIX; i++) mem[i] <= 4'd0;
            for (int i = 0; i < 3; i++) begin
                rd_a[i] <= 19'd0;
                rd_d[i] <= 4'd0;
            end
        end else begin
            rd_a[0] <= hist_read_addr;
            rd_d[0] <= mem[hist_read_addr];
            rd_a[1] <= rd_a[0];
            rd_d[1] <= rd_d[0];
            rd_a[2] <= rd_a[1];
            rd_d[2] <= rd_d[1];
            if (hist_write_en) mem[hist_write_addr] <= hist_write_data;
        end
    end

    assign hist_read_data      = rd_d[2];
    assign hist_just_read_addr = rd_a[2] ^ {18'd0, corrupt};

    // ------------------------------------------------------------------------
    // Reference: history per address, updated in strict pixel order.
    // ------------------------------------------------------------------------
    logic [3:0] gold [0:c_NPIX-1];

    typedef struct packed {
        logic [18:0] addr;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [3:0]  wd;
    } exp_t;

    exp_t exp_q [0:c_QLEN-1];
    int   wr_ptr = 0;
    int   rd_ptr = 0;

    function automatic logic [3:0] ref_update(input logic [3:0] old, input logic [1:0] k);
        int c = int'(old[3:2]);
        int n = int'(old[1:0]);
        if (int'(k) == c) begin
            n = (n < 3) ? n + 1 : 3;
        end else if (n > 0) begin
            n = n - 1;
        end else begin
            c = int'(k);
            n = 0;
        end
        return {c[1:0], n[1:0]};
    endfunction

    task automatic drive(input logic v, input int x, input int y, input int k);
        int          a;
        logic [3:0]  nw;
        exp_t        e;
        @(negedge clk);
        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        pix_class = 2'(k);
        if (v && pix_ready) begin
            a       = y * 640 + x;
            nw      = ref_update(gold[a], 2'(k));
            gold[a] = nw;
            e.addr  = 19'(a);
            e.x     = 10'(x);
            e.y     = 9'(y);
            e.wd    = nw;
            exp_q[wr_ptr % c_QLEN] = e;
            wr_ptr++;
        end
    endtask

    task automatic drive_random(input int cycles);
        int x;
        int y;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
            end else begin
                x = $urandom_range(0, 7);
                y = $urandom_range(0, 3);
            end
            drive($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 3));
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && rd_ptr != wr_ptr; i++) @(negedge clk);
        check_eq(tag, rd_ptr, wr_ptr);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rd_addr"}, {13'd0, hist_read_addr}, 32'd0);
        check_eq({tag, "_wr"}, {8'd0, hist_write_addr, hist_write_data, hist_write_en}, 32'd0);
        check_eq({tag, "_out"}, {7'd0, pix_ready, out_valid, out_x, out_y, out_color, out_stable, addr_mismatch}, 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard: compare every write-back / output against the reference,
    // and confirm the output fields hold between strobes.
    // ------------------------------------------------------------------------
    logic [21:0] last_out;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_ptr   = wr_ptr;
            last_out = 22'd0;
        end else begin
            check_eq("we_vs_ov", {31'd0, hist_write_en}, {31'd0, out_valid});
            if (out_valid) begin
                if (rd_ptr == wr_ptr) begin
                    check_eq("out_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q[rd_ptr % c_QLEN];
                    rd_ptr++;
                    check_eq("wr_addr", {13'd0, hist_write_addr}, {13'd0, e.addr});
                    check_eq("wr_data", {28'd0, hist_write_data}, {28'd0, e.wd});
                    check_eq("out_xy", {13'd0, out_x, out_y}, {13'd0, e.x, e.y});
                    check_eq("out_color", {30'd0, out_color}, {30'd0, e.wd[3:2]});
                    check_eq("out_stable", {31'd0, out_stable}, {31'd0, (e.wd[1:0] >= 2'd2)});
                    last_out = {e.x, e.y, e.wd[3:2], (e.wd[1:0] >= 2'd2)};
                end
            end else begin
                check_eq("out_hold", {10'd0, out_x, out_y, out_color, out_stable}, {10'd0, last_out});
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int bad;
        reset           = 1'b1;
        pix_valid       = 1'b0;
        pix_x           = 10'd0;
        pix_y           = 9'd0;
        pix_class       = 2'd0;
        hist_data_valid = 1'b0;
        corrupt         = 1'b0;
        for (int i = 0; i < c_NPIX; i++) gold[i] = 4'd0;
        repeat (3) @(posedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Memory still clearing: nothing may be accepted or written.
        bad = 0;
        pix_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (pix_ready || hist_write_en || out_valid) bad++;
        end
        check_eq("prime_hold", bad, 0);
        check_eq("prime_rd_addr", {13'd0, hist_read_addr}, 32'd0);
        pix_valid       = 1'b0;
        hist_data_valid = 1'b1;
        @(negedge clk);
        check_eq("run_ready", {31'd0, pix_ready}, 32'd1);

        // Single pixel, cleared memory: address and first update.
        drive(1'b1, 5, 2, 1);
        @(posedge clk);
        #1 check_eq("rd_addr_1285", {13'd0, hist_read_addr}, 32'd1285);
        idle(10);

        // Same pixel over three frames, building confidence to stable.
        for (int f = 0; f < 3; f++) begin
            drive(1'b1, 7, 3, 1);
            idle(10);
        end

        // Erosion then colour replacement: 1000, 1001, 1000, 0100.
        drive(1'b1, 9, 9, 2);
        drive(1'b1, 9, 9, 2);
        idle(8);
        drive(1'b1, 9, 9, 1);
        idle(8);
        drive(1'b1, 9, 9, 1);
        idle(8);

        // Back-to-back hits on one address rely on forwarding.
        drive(1'b1, 11, 4, 3);
        drive(1'b1, 11, 4, 3);
        idle(10);
        drain("drain_directed");

        drive_random(3000);
        idle(10);
        drain("drain_random");
        check_eq("no_mismatch", {31'd0, addr_mismatch}, 32'd0);

        // Corrupt the returned address for exactly one emerging tag.
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
            corrupt = (i == 20);
        end
        corrupt = 1'b0;
        idle(10);
        check_eq("mismatch_set", {31'd0, addr_mismatch}, 32'd1);
        drive_random(200);
        idle(10);
        check_eq("mismatch_sticky", {31'd0, addr_mismatch}, 32'd1);
        drain("drain_corrupt");

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) drive(1'b1, i, 1, 2);
        @(posedge clk);
        #2 reset = 1'b1;
        hist_data_valid = 1'b0;
        #1 check_reset_state("async_rst");
        pix_valid = 1'b0;
        for (int i = 0; i < c_NPIX; i++) gold[i] = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(5);
        check_eq("reprime_ready", {31'd0, pix_ready}, 32'd0);
        hist_data_valid = 1'b1;
        idle(10);
        check_eq("post_rst_mismatch", {31'd0, addr_mismatch}, 32'd0);
        drive_random(500);
        idle(10);
        drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
